// File: rtl/mul_red_sched_if.sv
// Request, datapath and result signals of the modular multiply/reduce scheduler.
interface mul_red_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [23:0] req0_a;
  logic [23:0] req0_w;
  logic        req0_mode;
  logic [1:0]  req0_sel;
  logic        req1_valid;
  logic        req1_ready;
  logic [23:0] req1_a;
  logic [23:0] req1_w;
  logic        req1_mode;
  logic [1:0]  req1_sel;
  logic [23:0] dp_a;
  logic [23:0] dp_w;
  logic [1:0]  dp_sel_a;
  logic        dp_mode;
  logic [23:0] dp_result;
  logic        res_valid;
  logic        res_id;
  logic [23:0] res_data;
  logic        busy;

  // Requesters plus datapath side
  modport master (
    output req0_valid, req0_a, req0_w, req0_mode, req0_sel,
    output req1_valid, req1_a, req1_w, req1_mode, req1_sel,
    output dp_result,
    input  req0_ready, req1_ready, dp_a, dp_w, dp_sel_a, dp_mode,
    input  res_valid, res_id, res_data, busy
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_a, req0_w, req0_mode, req0_sel,
    input  req1_valid, req1_a, req1_w, req1_mode, req1_sel,
    input  dp_result,
    output req0_ready, req1_ready, dp_a, dp_w, dp_sel_a, dp_mode,
    output res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/mul_red_sched.sv
// Sequencing controller for the shared 24-bit multiply/reduce datapath.
// Optional MUL_RED_SCHED_PERF_EN adds issue/stall performance counters.
module mul_red_sched #(
  parameter int unsigned PIPE_LAT   = 4,
  parameter int unsigned SWITCH_GAP = 7
) (
  input  logic           clk,
  input  logic           rst,
  mul_red_sched_if.slave bus
`ifdef MUL_RED_SCHED_PERF_EN
  ,
  output logic [31:0]    perf_issue,
  output logic [31:0]    perf_stall
`endif
);

  localparam int unsigned CW = $clog2(PIPE_LAT + 1);
  localparam int unsigned GW = $clog2(SWITCH_GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_GAP} state_e;
  typedef struct packed {
    logic vld;
    logic id;
    logic mode;
  } pipe_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    cur_sel_q, cur_sel_d;
  logic [1:0]    frz_sel_q, frz_sel_d;
  logic          prio_q, prio_d;
  logic          mode_hold_q;
  pipe_t         pipe_q [PIPE_LAT];
  logic          res_valid_q, res_id_q;
  logic [23:0]   res_data_q;

  logic          any_c, win_c, win_mode_c, issue_c, retire_c;
  logic [1:0]    win_sel_c;
  logic [23:0]   win_a_c, win_w_c;
  pipe_t         tail_c;

  assign tail_c   = pipe_q[PIPE_LAT-1];
  assign retire_c = tail_c.vld;

  // Round-robin candidate selection
  always_comb begin
    any_c = bus.req0_valid | bus.req1_valid;
    win_c = prio_q;
    if (bus.req0_valid && !bus.req1_valid) win_c = 1'b0;
    else if (!bus.req0_valid && bus.req1_valid) win_c = 1'b1;
    win_sel_c  = win_c ? bus.req1_sel  : bus.req0_sel;
    win_mode_c = win_c ? bus.req1_mode : bus.req0_mode;
    win_a_c    = win_c ? bus.req1_a    : bus.req0_a;
    win_w_c    = win_c ? bus.req1_w    : bus.req0_w;
  end

  // Next state, issue decision, sel switch sequencing
  always_comb begin
    state_d   = state_q;
    issue_c   = 1'b0;
    prio_d    = prio_q;
    cur_sel_d = cur_sel_q;
    frz_sel_d = frz_sel_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (rst && any_c && (win_sel_c != cur_sel_q)) begin
          // Freeze the winner by parking the pointer on it
          state_d   = S_DRAIN;
          prio_d    = win_c;
          frz_sel_d = win_sel_c;
        end else begin
          if (rst && any_c) begin
            issue_c = 1'b1;
            prio_d  = ~win_c;
          end
          state_d = (issue_c || (cnt_q != CW'(retire_c))) ? S_RUN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d   = S_GAP;
          cur_sel_d = frz_sel_q;
          gap_d     = '0;
        end
      end
      S_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(SWITCH_GAP - 1)) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // In-flight beat counter
  always_comb begin
    cnt_d = cnt_q;
    if (issue_c && !retire_c) cnt_d = cnt_q + CW'(1);
    else if (!issue_c && retire_c) cnt_d = cnt_q - CW'(1);
  end

  assign bus.req0_ready = issue_c & ~win_c;
  assign bus.req1_ready = issue_c & win_c;
  assign bus.dp_a       = issue_c ? win_a_c : 24'd0;
  assign bus.dp_w       = issue_c ? win_w_c : 24'd0;
  assign bus.dp_sel_a   = cur_sel_q;
  assign bus.dp_mode    = tail_c.vld ? tail_c.mode : mode_hold_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_data   = res_data_q;
  assign bus.busy       = (cnt_q != '0) || (state_q != S_IDLE);

  // State, tag pipeline and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      cur_sel_q   <= '0;
      frz_sel_q   <= '0;
      prio_q      <= 1'b0;
      mode_hold_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      cur_sel_q   <= cur_sel_d;
      frz_sel_q   <= frz_sel_d;
      prio_q      <= prio_d;
      if (tail_c.vld) mode_hold_q <= tail_c.mode;
      res_valid_q <= tail_c.vld;
      res_id_q    <= tail_c.vld & tail_c.id;
      res_data_q  <= tail_c.vld ? bus.dp_result : 24'd0;
      pipe_q[0]   <= '{vld: issue_c, id: win_c & issue_c, mode: win_mode_c & issue_c};
      for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef MUL_RED_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  // Saturating issue and switch-stall counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (issue_c && (perf_issue_q != '1)) perf_issue_q <= perf_issue_q + 32'd1;
      if (((state_q == S_DRAIN) || (state_q == S_GAP)) && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_red_sched.sv
// Directed bench for mul_red_sched with a fixed-latency datapath model.
module tb_mul_red_sched;
  localparam int unsigned PIPE_LAT = 4;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic [23:0] dl [PIPE_LAT];

  mul_red_sched_if bus ();

`ifdef MUL_RED_SCHED_PERF_EN
  logic [31:0] perf_issue, perf_stall;
`endif

  mul_red_sched #(.PIPE_LAT(PIPE_LAT), .SWITCH_GAP(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MUL_RED_SCHED_PERF_EN
    ,
    .perf_issue (perf_issue),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dp_fn(input logic [23:0] a, input logic [23:0] w);
    if (a == 24'h000123 && w == 24'h000456) return 24'h0A0B0C;
    return a + w;
  endfunction

  // Datapath model: result appears PIPE_LAT cycles after operands
  always @(posedge clk) begin
    dl[0] <= dp_fn(bus.dp_a, bus.dp_w);
    for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
  end
  assign bus.dp_result = dl[PIPE_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_w = '0; bus.req0_mode = 0; bus.req0_sel = '0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_w = '0; bus.req1_mode = 0; bus.req1_sel = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    tick();
    tick();
    total_cnt++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) $display("FAIL reset_ready got %b%b exp 00", bus.req0_ready, bus.req1_ready); else pass_cnt++;
    total_cnt++; if (bus.dp_a !== 24'd0 || bus.dp_w !== 24'd0) $display("FAIL reset_dp got %h %h exp 0 0", bus.dp_a, bus.dp_w); else pass_cnt++;
    total_cnt++; if (bus.dp_sel_a !== 2'd0 || bus.dp_mode !== 1'b0) $display("FAIL reset_sel_mode got %h %b exp 0 0", bus.dp_sel_a, bus.dp_mode); else pass_cnt++;
    total_cnt++; if (bus.res_valid !== 1'b0 || bus.res_id !== 1'b0 || bus.res_data !== 24'd0) $display("FAIL reset_res got %b %b %h exp 0 0 0", bus.res_valid, bus.res_id, bus.res_data); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
    rst = 1;
  endtask

  task automatic test_single_beat();
    bus.req0_valid = 1; bus.req0_a = 24'h000123; bus.req0_w = 24'h000456; bus.req0_mode = 0; bus.req0_sel = 2'd0;
    #1;
    total_cnt++; if (bus.req0_ready !== 1'b1) $display("FAIL single_ready got %b exp 1", bus.req0_ready); else pass_cnt++;
    total_cnt++; if (bus.dp_a !== 24'h000123 || bus.dp_w !== 24'h000456) $display("FAIL single_operands got %h %h exp 000123 000456", bus.dp_a, bus.dp_w); else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total_cnt++; if (bus.dp_a !== 24'd0) $display("FAIL single_dp_a_idle got %h exp 0", bus.dp_a); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (bus.dp_mode !== 1'b0) $display("FAIL single_dp_mode got %b exp 0", bus.dp_mode); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) $display("FAIL single_inflight got busy %b res_valid %b exp 1 0", bus.busy, bus.res_valid); else pass_cnt++;
    tick();
    total_cnt++; if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b0 || bus.res_data !== 24'h0A0B0C) $display("FAIL single_result got %b %b %h exp 1 0 0a0b0c", bus.res_valid, bus.res_id, bus.res_data); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_busy_done got %b exp 0", bus.busy); else pass_cnt++;
    tick();
  endtask

  task automatic test_contention();
    logic exp_g;
    logic exp_rv;
    apply_reset();
    for (int j = 0; j <= 10; j++) begin
      exp_rv = (j >= 5);
      total_cnt++; if (bus.res_valid !== exp_rv) $display("FAIL contention_res_valid j=%0d got %b exp %b", j, bus.res_valid, exp_rv); else pass_cnt++;
      if (j >= 5) begin
        exp_g = 1'((j - 5) % 2);
        total_cnt++; if (bus.res_id !== exp_g || bus.res_data !== (exp_g ? 24'h22 : 24'h11)) $display("FAIL contention_res j=%0d got id %b data %h exp id %b", j, bus.res_id, bus.res_data, exp_g); else pass_cnt++;
      end
      if (j < 6) begin
        bus.req0_valid = 1; bus.req0_a = 24'h10; bus.req0_w = 24'h1; bus.req0_sel = 2'd0;
        bus.req1_valid = 1; bus.req1_a = 24'h20; bus.req1_w = 24'h2; bus.req1_sel = 2'd0;
      end else clear_inputs();
      #1;
      if (j < 6) begin
        exp_g = 1'(j % 2);
        total_cnt++; if (bus.req0_ready !== ~exp_g || bus.req1_ready !== exp_g) $display("FAIL contention_grant j=%0d got %b%b exp port %b", j, bus.req1_ready, bus.req0_ready, exp_g); else pass_cnt++;
        total_cnt++; if (bus.dp_a !== (exp_g ? 24'h20 : 24'h10)) $display("FAIL contention_dp_a j=%0d got %h", j, bus.dp_a); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_sel_switch();
    logic       exp_r, exp_rv;
    logic [1:0] exp_sel;
    apply_reset();
    for (int j = 0; j <= 21; j++) begin
      exp_rv  = (j >= 5 && j <= 7) || (j == 20);
      exp_sel = (j >= 8) ? 2'd1 : 2'd0;
      total_cnt++; if (bus.res_valid !== exp_rv) $display("FAIL switch_res_valid j=%0d got %b exp %b", j, bus.res_valid, exp_rv); else pass_cnt++;
      if (j == 20) begin
        total_cnt++; if (bus.res_data !== 24'h41 || bus.res_id !== 1'b0) $display("FAIL switch_res_data got %h id %b exp 000041 0", bus.res_data, bus.res_id); else pass_cnt++;
      end
      total_cnt++; if (bus.dp_sel_a !== exp_sel) $display("FAIL switch_dp_sel_a j=%0d got %0d exp %0d", j, bus.dp_sel_a, exp_sel); else pass_cnt++;
      clear_inputs();
      if (j < 3) begin
        bus.req0_valid = 1; bus.req0_a = 24'h30 + 24'(j); bus.req0_sel = 2'd0;
      end else if (j <= 15) begin
        bus.req0_valid = 1; bus.req0_a = 24'h40; bus.req0_w = 24'h1; bus.req0_sel = 2'd1;
      end
      #1;
      exp_r = (j < 3) || (j == 15);
      total_cnt++; if (bus.req0_ready !== exp_r) $display("FAIL switch_ready j=%0d got %b exp %b", j, bus.req0_ready, exp_r); else pass_cnt++;
      tick();
    end
`ifdef MUL_RED_SCHED_PERF_EN
    total_cnt++; if (perf_issue !== 32'd4) $display("FAIL perf_issue got %0d exp 4", perf_issue); else pass_cnt++;
    total_cnt++; if (perf_stall !== 32'd11) $display("FAIL perf_stall got %0d exp 11", perf_stall); else pass_cnt++;
`endif
  endtask

  task automatic test_mixed_mode();
    logic exp_m, exp_rv;
    for (int j = 0; j <= 8; j++) begin
      exp_rv = (j >= 5 && j <= 7);
      total_cnt++; if (bus.res_valid !== exp_rv || (exp_rv && bus.res_id !== 1'b1)) $display("FAIL mixed_res j=%0d got %b id %b exp %b id 1", j, bus.res_valid, bus.res_id, exp_rv); else pass_cnt++;
      if (j >= 3 && j <= 8) begin
        exp_m = (j == 3 || j == 5) ? 1'b0 : 1'b1;
        total_cnt++; if (bus.dp_mode !== exp_m) $display("FAIL mixed_dp_mode j=%0d got %b exp %b", j, bus.dp_mode, exp_m); else pass_cnt++;
      end
      clear_inputs();
      if (j < 3) begin
        bus.req1_valid = 1; bus.req1_a = 24'h60 + 24'(j); bus.req1_sel = 2'd1; bus.req1_mode = (j != 1);
      end
      #1;
      total_cnt++; if (bus.req1_ready !== (j < 3)) $display("FAIL mixed_ready j=%0d got %b exp %b", j, bus.req1_ready, (j < 3)); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    for (int j = 0; j <= 10; j++) begin
      if (j == 4) begin
        total_cnt++; if (bus.dp_mode !== 1'b1 || bus.busy !== 1'b1) $display("FAIL midreset_pre got mode %b busy %b exp 1 1", bus.dp_mode, bus.busy); else pass_cnt++;
      end
      if (j == 5) begin
        total_cnt++; if (bus.dp_sel_a !== 2'd0 || bus.dp_mode !== 1'b0) $display("FAIL midreset_sel_mode got %0d %b exp 0 0", bus.dp_sel_a, bus.dp_mode); else pass_cnt++;
        total_cnt++; if (bus.res_id !== 1'b0 || bus.res_data !== 24'd0 || bus.busy !== 1'b0) $display("FAIL midreset_outputs got id %b data %h busy %b exp 0 0 0", bus.res_id, bus.res_data, bus.busy); else pass_cnt++;
        total_cnt++; if (bus.dp_a !== 24'd0 || bus.req0_ready !== 1'b0) $display("FAIL midreset_dp got %h ready %b exp 0 0", bus.dp_a, bus.req0_ready); else pass_cnt++;
      end
      if (j >= 5) begin
        total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL midreset_res_valid j=%0d got %b exp 0", j, bus.res_valid); else pass_cnt++;
      end
      clear_inputs();
      if (j < 3) begin
        bus.req0_valid = 1; bus.req0_a = 24'h70 + 24'(j); bus.req0_sel = 2'd1; bus.req0_mode = 1;
      end
      rst = (j == 4) ? 1'b0 : 1'b1;
      #1;
      if (j < 3) begin
        total_cnt++; if (bus.req0_ready !== 1'b1) $display("FAIL midreset_issue j=%0d got %b exp 1", j, bus.req0_ready); else pass_cnt++;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0;
    rst = 0;
    pass_cnt = 0;
    total_cnt = 0;
    for (int i = 0; i < PIPE_LAT; i++) dl[i] = '0;
    clear_inputs();
    test_reset();
    test_single_beat();
    test_contention();
    test_sel_switch();
    test_mixed_mode();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
